seq_mult_param: RTL and testbench
=================================

# seq_mult_param

Parametrised sequential shift-add multiplier with a start/ready handshake and run-time signed/unsigned mode. It is the next-generation replacement for the fixed 8-bit unsigned sequential multiplier and is used wherever a single-cycle array multiplier is too large. Operands are latched when a request is accepted. The product is produced after a fixed WIDTH+1 cycles, with a one-cycle done pulse.

## Interface
- WIDTH, 8, operand width in bits; legal range is 2 and above. Product width is 2*WIDTH.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request strobe; sampled only while ready=1.
- is_signed  in  1  1 treats operands as two's complement, 0 as unsigned; latched on accept.
- multiplicand  in  WIDTH  operand A; latched on accept.
- multiplier  in  WIDTH  operand B; latched on accept.
- ready  out  1  1 when idle and able to accept start.
- busy  out  1  1 while a multiplication is in progress; always equal to !ready.
- done  out  1  one-cycle pulse marking that product has just been updated.
- product  out  2*WIDTH  result register; holds its value until the next done.

## Operation
- States:
  - IDLE: ready=1.
  - MULT: WIDTH iterations.
  - FIX: sign correction and write of product.
- IDLE, start=1: transition to MULT. On this edge:
  - Latch mode.
  - Latch operand magnitudes into mcand_r and mplier_r. In signed mode a negative operand is replaced by its two's-complement negation; -2^(WIDTH-1) gives magnitude 2^(WIDTH-1), which fits in WIDTH unsigned bits.
  - Latch neg = is_signed & (A[msb] ^ B[msb]).
  - Clear acc (2*WIDTH bits) and load count=WIDTH.
- MULT, each cycle:
  - If mplier_r[0]=1, add mcand_r, shifted left by (WIDTH-count), into acc.
  - Shift mplier_r right by 1 and decrement count.
  - When count reaches 1 the iteration executes and the next state is FIX. Exactly WIDTH MULT cycles occur.
- FIX (1 cycle):
  - product <= neg ? -acc : acc, truncated to 2*WIDTH bits.
  - done <= 1 and state <= IDLE.
- The result is exact for every operand pair in both modes. No overflow is possible: the signed extreme (-2^(W-1))^2 = 2^(2W-2) fits.
- start while busy=1 is ignored. Operand and mode changes after accept do not affect the running operation.
- Iteration count is fixed: there is no early termination on zero operands.
- Reset (asynchronous, at any time, including mid-operation):
  - state=IDLE, ready=1, busy=0, done=0, product=0.
  - Internal acc, count and operand registers are cleared.
  - The in-flight result is discarded.

## Timing
- Accept edge T0 (start=1, ready=1): ready falls and busy rises after T0.
- Edges T1..TWIDTH are the MULT iterations; edge TWIDTH+1 is FIX.
- After edge TWIDTH+1: product valid, done=1, and ready=1, all in the same cycle.
- Latency from accept edge to valid product is WIDTH+1 cycles; WIDTH=8 gives 9.
- done is high for exactly one cycle. It is low at all other times, including after reset.
- A start held high during the done cycle is accepted on the next edge (back-to-back). Minimum issue interval is WIDTH+2 cycles.
- A start held continuously high re-issues a new operation each time ready=1.
- Deassertion of reset is synchronous-safe: the first accept is possible on the first rising edge after reset falls.

## Test plan
- Reset behaviour: assert reset mid-cycle at power-up -> product=0, ready=1, busy=0, done=0 immediately, with no clock needed.
- Basic unsigned, WIDTH=8, is_signed=0:
  - 8*12 -> product=0x0060 with done exactly 9 cycles after accept.
  - Then 30*4 -> 0x0078.
  - Then 255*255 -> 0xFE01.
- Signed, WIDTH=8, is_signed=1:
  - (-3)*5 (0xFD, 0x05) -> 0xFFF1.
  - (-128)*(-128) -> 0x4000.
  - 127*(-128) -> 0xC080.
  - 0x00*0x80 -> 0x0000.
- Busy protection: accept 7*9, pulse start with 2*2 at cycle 3 and change operands/mode every cycle -> product=0x003F, only one done, ready low for 9 cycles.
- Back-to-back: hold start=1 with 6*7 then 5*5 presented in the done cycle -> done pulses 10 cycles apart with products 0x002A then 0x0019.
- Reset mid-operation, plus WIDTH=16 unsigned:
  - Assert reset at MULT cycle 4 of 200*200 -> product stays 0 and no done; the next request 3*3 gives 0x0009.
  - Rerun with WIDTH=16 unsigned: 0xFFFF*0xFFFF -> 0xFFFE0001 after 17 cycles.

Source files
------------

// File: rtl/seq_mult_param.sv
// seq_mult_param: sequential shift-add multiplier, WIDTH-bit operands, 2*WIDTH-bit product,
// run-time signed/unsigned mode, start/ready handshake, result WIDTH+1 cycles after accept.
// Ports: clk, reset (async, active-high), start, is_signed, multiplicand, multiplier (inputs);
//        ready, busy (= !ready), done (one-cycle pulse), product (held until next done) (outputs).
module seq_mult_param #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] W_C = CW'(WIDTH);
    typedef enum logic [1:0] {IDLE, MULT, FIX} state_t;
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d, mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, product_q, product_d;
    logic [CW-1:0]      count_q, count_d, shamt;
    logic               neg_q, neg_d, done_q, done_d, a_neg, b_neg;
    always_comb begin
        a_neg     = is_signed & multiplicand[WIDTH-1];
        b_neg     = is_signed & multiplier[WIDTH-1];
        shamt     = W_C - count_q;
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        count_d   = count_q;
        neg_d     = neg_q;
        product_d = product_q;
        done_d    = 1'b0;
        if (state_q == IDLE && start) begin
            // Work on magnitudes; -2^(WIDTH-1) negates to itself, which is the right unsigned magnitude.
            state_d  = MULT;
            mcand_d  = a_neg ? -multiplicand : multiplicand;
            mplier_d = b_neg ? -multiplier : multiplier;
            neg_d    = a_neg ^ b_neg;
            acc_d    = '0;
            count_d  = W_C;
        end else if (state_q == MULT) begin
            acc_d    = mplier_q[0] ? acc_q + ({{WIDTH{1'b0}}, mcand_q} << shamt) : acc_q;
            mplier_d = mplier_q >> 1;
            count_d  = count_q - CW'(1);
            state_d  = (count_q == CW'(1)) ? FIX : MULT;
        end else if (state_q == FIX) begin
            product_d = neg_q ? -acc_q : acc_q;
            done_d    = 1'b1;
            state_d   = IDLE;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            neg_q     <= neg_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end
    assign ready   = (state_q == IDLE);
    assign busy    = !ready;
    assign done    = done_q;
    assign product = product_q;
endmodule

// File: tb/tb_seq_mult_param.sv
// tb_seq_mult_param: scoreboard bench for seq_mult_param at WIDTH=8 and WIDTH=16.
module tb_seq_mult_param;
    typedef struct {
        logic [63:0] exp;
        int          acc;
    } item_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst8 = 1'b0, start8 = 1'b0, sgn8 = 1'b0, ready8, busy8, done8;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] p8;
    logic        rst16 = 1'b0, start16 = 1'b0, sgn16 = 1'b0, ready16, busy16, done16;
    logic [15:0] a16 = '0, b16 = '0;
    logic [31:0] p16;

    int    cyc = 0;
    int    checks = 0, errors = 0;
    bit    fin16 = 1'b0;
    item_t q8[$], q16[$];

    seq_mult_param #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(rst8), .start(start8), .is_signed(sgn8),
        .multiplicand(a8), .multiplier(b8),
        .ready(ready8), .busy(busy8), .done(done8), .product(p8));

    seq_mult_param #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(rst16), .start(start16), .is_signed(sgn16),
        .multiplicand(a16), .multiplier(b16),
        .ready(ready16), .busy(busy16), .done(done16), .product(p16));

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer product of the operands as interpreted by the mode.
    function automatic logic [63:0] model(logic [63:0] a, logic [63:0] b, logic s, int w);
        longint x = longint'(a);
        longint y = longint'(b);
        if (s && a[w-1]) x = x - (longint'(1) << w);
        if (s && b[w-1]) y = y - (longint'(1) << w);
        return 64'(x * y) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        item_t it;
        check("busy8_vs_ready8", 64'(busy8), 64'(!ready8));
        if (done8) begin
            if (q8.size() == 0) check("spurious_done8", 64'(done8), 64'd0);
            else begin
                it = q8.pop_front();
                check("product8", 64'(p8), it.exp);
                check("latency8", 64'(cyc - it.acc), 64'd9);
            end
        end
    end

    always @(negedge clk) begin
        item_t it;
        check("busy16_vs_ready16", 64'(busy16), 64'(!ready16));
        if (done16) begin
            if (q16.size() == 0) check("spurious_done16", 64'(done16), 64'd0);
            else begin
                it = q16.pop_front();
                check("product16", 64'(p16), it.exp);
                check("latency16", 64'(cyc - it.acc), 64'd17);
            end
        end
    end

    // Called at a negedge; waits for ready, presents the request, records the expected result.
    task automatic issue8(logic [7:0] a, logic [7:0] b, logic s, bit hold);
        int n = 0;
        while (!ready8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready8) begin
            check("ready8_timeout", 64'(ready8), 64'd1);
            return;
        end
        a8 = a; b8 = b; sgn8 = s; start8 = 1'b1;
        q8.push_back('{model(64'(a), 64'(b), s, 8), cyc + 1});
        @(negedge clk);
        if (!hold) start8 = 1'b0;
    endtask

    task automatic issue16(logic [15:0] a, logic [15:0] b, logic s);
        int n = 0;
        while (!ready16 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready16) begin
            check("ready16_timeout", 64'(ready16), 64'd1);
            return;
        end
        a16 = a; b16 = b; sgn16 = s; start16 = 1'b1;
        q16.push_back('{model(64'(a), 64'(b), s, 16), cyc + 1});
        @(negedge clk);
        start16 = 1'b0;
    endtask

    initial begin
        #1 rst16 = 1'b1;
        #1 check("reset16_product", 64'(p16), 64'd0);
        @(negedge clk);
        rst16 = 1'b0;
        issue16(16'hFFFF, 16'hFFFF, 1'b0);
        issue16(16'h8000, 16'h8000, 1'b1);
        for (int i = 0; i < 15; i++) issue16(16'($urandom), 16'($urandom), 1'($urandom));
        for (int i = 0; i < 40 && q16.size() != 0; i++) @(negedge clk);
        check("drain16", 64'(q16.size()), 64'd0);
        fin16 = 1'b1;
    end

    initial begin
        logic [7:0] ta[7] = '{8'd8, 8'd30, 8'd255, 8'hFD, 8'h80, 8'd127, 8'h00};
        logic [7:0] tb[7] = '{8'd12, 8'd4, 8'd255, 8'h05, 8'h80, 8'h80, 8'h80};
        logic       ts[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        #1 rst8 = 1'b1;
        #1;
        check("reset8_product", 64'(p8), 64'd0);
        check("reset8_ready", 64'(ready8), 64'd1);
        check("reset8_busy", 64'(busy8), 64'd0);
        check("reset8_done", 64'(done8), 64'd0);
        @(negedge clk);
        rst8 = 1'b0;
        for (int i = 0; i < 7; i++) issue8(ta[i], tb[i], ts[i], 1'b0);
        // Busy protection: junk on every input while the operation runs.
        issue8(8'd7, 8'd9, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            check("ready8_low_while_busy", 64'(ready8), 64'd0);
            a8 = (i == 2) ? 8'd2 : 8'($urandom);
            b8 = (i == 2) ? 8'd2 : 8'($urandom);
            sgn8 = 1'($urandom);
            start8 = (i == 2);
            @(negedge clk);
        end
        start8 = 1'b0;
        // Back-to-back: start held through the done cycle.
        issue8(8'd6, 8'd7, 1'b0, 1'b1);
        issue8(8'd5, 8'd5, 1'b0, 1'b0);
        // Reset mid-operation discards the in-flight result.
        issue8(8'd200, 8'd200, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst8 = 1'b1;
        q8.delete();
        #1;
        check("midreset8_product", 64'(p8), 64'd0);
        check("midreset8_ready", 64'(ready8), 64'd1);
        check("midreset8_done", 64'(done8), 64'd0);
        @(negedge clk);
        rst8 = 1'b0;
        issue8(8'd3, 8'd3, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) issue8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        start8 = 1'b0;
        for (int i = 0; i < 40 && q8.size() != 0; i++) @(negedge clk);
        check("drain8", 64'(q8.size()), 64'd0);
        for (int i = 0; i < 2000 && !fin16; i++) @(negedge clk);
        check("finish16", 64'(fin16), 64'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
